alu_issue_stage: RTL and testbench

//  Decode/issue stage feeding the 64-bit integer ALU. Accepts a 32-bit RV64 OP/OP-IMM instruction and reads rs1/rs2 from the external register file.

---
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage in front of the 64-bit integer ALU.
// Decodes RV64 OP / OP-IMM, reads rs1/rs2 from the external regfile and
// registers the ALU operands and controls behind a valid/ready handshake.
// A per-register busy scoreboard holds back RAW hazards until writeback.
// Optional feature: define ISSUE_BYPASS_EN to forward wb_data into a
// source operand that is retiring in the same cycle (no stall on it).
module alu_issue_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int NREGS      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] in2,
    output logic [3:0]            func3,
    output logic [3:0]            func7,
    output logic [4:0]            out_rd,
    output logic                  illegal
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] in1;
        logic [DATA_WIDTH-1:0] in2;
        logic [3:0]            f3;
        logic [3:0]            f7;
        logic [4:0]            rd;
    } issue_t;

    issue_t                op_q, op_d;
    logic [NREGS-1:0]      busy, busy_nxt;
    logic                  is_op, is_opimm, legal;
    logic [2:0]            f3;
    logic [4:0]            rd;
    logic                  rs1_fwd, rs2_fwd;
    logic [DATA_WIDTH-1:0] src1, src2;
    logic                  rs1_busy, rs2_busy, stall, xfer, alt;

    assign is_op    = (instr[6:0] == OPC_OP);
    assign is_opimm = (instr[6:0] == OPC_OPIMM);
    assign legal    = is_op || is_opimm;
    assign f3       = instr[14:12];
    assign rd       = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

`ifdef ISSUE_BYPASS_EN
    // A source retiring this cycle takes wb_data and is not treated as busy.
    assign rs1_fwd = wb_valid && (wb_rd == rs1_addr) && (rs1_addr != 5'd0);
    assign rs2_fwd = wb_valid && (wb_rd == rs2_addr) && (rs2_addr != 5'd0);
    assign src1    = rs1_fwd ? wb_data : rs1_data;
    assign src2    = rs2_fwd ? wb_data : rs2_data;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
    assign src1    = rs1_data;
    assign src2    = rs2_data;
`endif

    // busy[0] is forced low in busy_nxt, so x0 never stalls.
    assign rs1_busy    = busy[rs1_addr] && !rs1_fwd;
    assign rs2_busy    = busy[rs2_addr] && !rs2_fwd;
    // Illegal opcodes have no real sources, so they never wait on the scoreboard.
    assign stall       = legal && (rs1_busy || (is_op && rs2_busy));
    assign instr_ready = !stall && (!out_valid || out_ready);
    assign xfer        = instr_valid && instr_ready;

    // SUB/SRA select: OP uses bit 30 for ADD/SUB and SRL/SRA; OP-IMM only for SRLI/SRAI.
    assign alt = instr[30] && (is_op ? ((f3 == 3'b000) || (f3 == 3'b101)) : (f3 == 3'b101));

    // Operand/control decode for the op being presented this cycle.
    always_comb begin
        op_d     = '0;
        op_d.in1 = src1;
        op_d.f3  = {1'b0, f3};
        op_d.f7  = {3'b000, alt};
        op_d.rd  = rd;
        if (is_op)
            op_d.in2 = src2;
        else if (f3 == 3'b001 || f3 == 3'b101)
            // Immediate shifts carry the funct7 bits in imm[11:6]; pass only the shamt.
            op_d.in2 = {{(DATA_WIDTH-6){1'b0}}, instr[25:20]};
        else
            op_d.in2 = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    end

    // Scoreboard update: writeback clears first so a same-cycle issue to that rd wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_rd] = 1'b0;
        if (xfer && legal && rd != 5'd0)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Output register, illegal pulse and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            op_q      <= '0;
            busy      <= '0;
        end else begin
            busy    <= busy_nxt;
            illegal <= xfer && !legal;
            if (xfer && legal) begin
                out_valid <= 1'b1;
                op_q      <= op_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign in1    = op_q.in1;
    assign in2    = op_q.in2;
    assign func3  = op_q.f3;
    assign func7  = op_q.f7;
    assign out_rd = op_q.rd;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scenarios plus a randomized run against a
// behavioural model of the issue rules (scoreboard as a set of pending rd).
module tb_alu_issue_stage;
    localparam int DW = 64;
`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready;
    logic [4:0]    rs1_addr, rs2_addr;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] in1, in2;
    logic [3:0]    func3, func7;
    logic [4:0]    out_rd;
    logic          illegal;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] regs [32];

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_WIDTH(DW), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .in1(in1), .in2(in2), .func3(func3),
        .func7(func7), .out_rd(out_rd), .illegal(illegal)
    );

    // Regfile read port; x0 is kept at zero by never writing it.
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    // ---------------- reference model ----------------
    logic [31:0]   m_busy;
    logic          m_valid, m_illegal;
    logic [DW-1:0] m_in1, m_in2;
    logic [3:0]    m_f3, m_f7;
    logic [4:0]    m_rd;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    function automatic logic f_is_op(input logic [31:0] i);
        return i[6:0] == 7'b0110011;
    endfunction

    function automatic logic f_is_opi(input logic [31:0] i);
        return i[6:0] == 7'b0010011;
    endfunction

    function automatic logic f_legal(input logic [31:0] i);
        return f_is_op(i) || f_is_opi(i);
    endfunction

    function automatic logic f_byp(input logic [4:0] r);
        return BYP && wb_valid && wb_rd == r && r != 5'd0;
    endfunction

    function automatic logic [DW-1:0] f_src(input logic [4:0] r);
        return f_byp(r) ? wb_data : regs[r];
    endfunction

    function automatic logic f_hz(input logic [4:0] r);
        return r != 5'd0 && m_busy[r] && !f_byp(r);
    endfunction

    function automatic logic f_ready();
        logic st;
        st = f_legal(instr) && (f_hz(instr[19:15]) || (f_is_op(instr) && f_hz(instr[24:20])));
        return !st && (!m_valid || out_ready);
    endfunction

    function automatic logic [DW-1:0] f_in2(input logic [31:0] i);
        logic signed [DW-1:0] simm;
        if (f_is_op(i)) return f_src(i[24:20]);
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) return DW'(i[25:20]);
        simm = $signed(i[31:20]);
        return simm;
    endfunction

    function automatic logic f_alt(input logic [31:0] i);
        if (f_is_op(i)) return i[30] && (i[14:12] == 3'd0 || i[14:12] == 3'd5);
        return i[30] && i[14:12] == 3'd5;
    endfunction

    function automatic logic [31:0] f_busy_next(input logic xf);
        logic [31:0] b;
        b = m_busy;
        if (wb_valid) b[wb_rd] = 1'b0;
        if (xf && f_legal(instr) && instr[11:7] != 5'd0) b[instr[11:7]] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // Model state advances on the same edge as the DUT, from the same inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= '0; m_valid <= 1'b0; m_illegal <= 1'b0;
            m_in1 <= '0; m_in2 <= '0; m_f3 <= '0; m_f7 <= '0; m_rd <= '0;
        end else begin
            m_busy    <= f_busy_next(instr_valid && f_ready());
            m_illegal <= instr_valid && f_ready() && !f_legal(instr);
            if (instr_valid && f_ready() && f_legal(instr)) begin
                m_valid <= 1'b1;
                m_in1   <= f_src(instr[19:15]);
                m_in2   <= f_in2(instr);
                m_f3    <= {1'b0, instr[14:12]};
                m_f7    <= {3'b000, f_alt(instr)};
                m_rd    <= instr[11:7];
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && wb_valid && wb_rd != 5'd0) regs[wb_rd] = wb_data;
    endtask

    task automatic idle();
        instr_valid = 1'b0; instr = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        regs[1] = 64'd5;
        regs[2] = 64'd7;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %0b want 0", illegal); end
        n_cmp++; if (in1 !== '0 || in2 !== '0) begin n_err++; $display("FAIL rst_operands got %0h %0h want 0 0", in1, in2); end
        n_cmp++; if (func3 !== 4'd0 || func7 !== 4'd0 || out_rd !== 5'd0) begin
            n_err++; $display("FAIL rst_ctrl got f3=%0d f7=%0d rd=%0d want 0 0 0", func3, func7, out_rd); end
        rst = 1'b0;
        regs[1] = 64'd5;
        regs[2] = 64'd7;
    endtask

    task automatic test_decode();
        do_reset();
        instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); instr_valid = 1'b1;
        #1;
        n_cmp++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
            n_err++; $display("FAIL dec_addr got %0d %0d want 1 2", rs1_addr, rs2_addr); end
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL dec_ready got %0b want 1", instr_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || in1 !== 64'd5 || in2 !== 64'd7 || func3 !== 4'd0 || func7 !== 4'd0 || out_rd !== 5'd3) begin
            n_err++; $display("FAIL add got v=%0b in1=%0h in2=%0h f3=%0d f7=%0d rd=%0d want 1 5 7 0 0 3",
                              out_valid, in1, in2, func3, func7, out_rd); end
        instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || func7 !== 4'd1 || out_rd !== 5'd4) begin
            n_err++; $display("FAIL sub got v=%0b f7=%0d rd=%0d want 1 1 4", out_valid, func7, out_rd); end
        instr = enc_i(12'h403, 5'd1, 3'd5, 5'd5);
        tick();
        n_cmp++; if (func3 !== 4'd5 || func7 !== 4'd1 || in2 !== 64'd3 || in1 !== 64'd5) begin
            n_err++; $display("FAIL srai got f3=%0d f7=%0d in2=%0h in1=%0h want 5 1 3 5", func3, func7, in2, in1); end
        instr = enc_i(12'hFFF, 5'd1, 3'd0, 5'd6);
        tick();
        n_cmp++; if (func3 !== 4'd0 || func7 !== 4'd0 || in2 !== 64'hFFFF_FFFF_FFFF_FFFF || out_rd !== 5'd6) begin
            n_err++; $display("FAIL addi got f3=%0d f7=%0d in2=%0h rd=%0d want 0 0 ffffffffffffffff 6",
                              func3, func7, in2, out_rd); end
        instr_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dec_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_hazard();
        do_reset();
        instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); instr_valid = 1'b1;
        tick();
        instr = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd7);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL hz_stall%0d got %0b want 0", k, instr_ready); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hz_bubble got %0b want 0", out_valid); end
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h99;
        #1;
`ifdef ISSUE_BYPASS_EN
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL hz_byp_ready got %0b want 1", instr_ready); end
        tick();
        wb_valid = 1'b0;
`else
        n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL hz_wb_ready got %0b want 0", instr_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL hz_after_wb got %0b want 1", instr_ready); end
        tick();
`endif
        instr_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in1 !== 64'h99 || out_rd !== 5'd7) begin
            n_err++; $display("FAIL hz_issue got v=%0b in1=%0h rd=%0d want 1 99 7", out_valid, in1, out_rd); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8); instr_valid = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd8) begin
            n_err++; $display("FAIL bp_first got v=%0b rd=%0d want 1 8", out_valid, out_rd); end
        instr = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd9);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got %0b want 0", k, instr_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd8 || in1 !== 64'd5 || in2 !== 64'd7 || func7 !== 4'd0) begin
                n_err++; $display("FAIL bp_hold%0d got v=%0b rd=%0d in1=%0h in2=%0h want 1 8 5 7", k, out_valid, out_rd, in1, in2); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %0b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || in1 !== 64'd7 || in2 !== 64'd5 || func7 !== 4'd1) begin
            n_err++; $display("FAIL bp_b2b got v=%0b rd=%0d in1=%0h in2=%0h f7=%0d want 1 9 7 5 1",
                              out_valid, out_rd, in1, in2, func7); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        instr = {12'h000, 5'd0, 3'b010, 5'd5, 7'b0000011}; instr_valid = 1'b1;
        #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got %0b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL ill_pulse got ill=%0b v=%0b want 1 0", illegal, out_valid); end
        tick();
        n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_once got %0b want 0", illegal); end
        instr = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6); instr_valid = 1'b1;
        #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL ill_nobusy got %0b want 1", instr_ready); end
        tick();
        instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0);
        tick();
        instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
        #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL x0_busy got %0b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre got %0b want 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_drop got %0b want 0", out_valid); end
        out_ready = 1'b1;
        instr = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd7); instr_valid = 1'b1;
        #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rm_nostall got %0b want 1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin
            n_err++; $display("FAIL rm_issue got v=%0b rd=%0d want 1 7", out_valid, out_rd); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] d, s1, s2;
        logic [2:0] f3;
        int k;
        d  = 5'($urandom_range(0, 7));
        s1 = 5'($urandom_range(0, 7));
        s2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        k  = $urandom_range(0, 7);
        if (k == 0) return {12'h000, 5'd0, f3, d, 7'b0000011};
        if (k <= 4) return enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, s2, s1, f3, d);
        return enc_i(12'($urandom), s1, f3, d);
    endfunction

    task automatic test_random();
        logic acc;
        logic [4:0] r;
        do_reset();
        acc = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!instr_valid || acc) begin
                instr_valid = ($urandom_range(0, 3) != 0);
                instr = rand_instr();
            end
            wb_valid = 1'b0;
            r = 5'($urandom_range(1, 7));
            if (m_busy[r] && $urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1; wb_rd = r; wb_data = {$urandom, $urandom};
            end
            #1;
            n_cmp++; if (instr_ready !== f_ready()) begin
                n_err++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, instr_ready, f_ready()); end
            acc = instr_valid && f_ready();
            tick();
            n_cmp++; if (out_valid !== m_valid || illegal !== m_illegal) begin
                n_err++; $display("FAIL rnd_valid c=%0d got v=%0b ill=%0b want %0b %0b", c, out_valid, illegal, m_valid, m_illegal); end
            if (m_valid) begin
                n_cmp++; if (in1 !== m_in1 || in2 !== m_in2 || func3 !== m_f3 || func7 !== m_f7 || out_rd !== m_rd) begin
                    n_err++; $display("FAIL rnd_op c=%0d got %0h %0h %0d %0d %0d want %0h %0h %0d %0d %0d", c,
                                      in1, in2, func3, func7, out_rd, m_in1, m_in2, m_f3, m_f7, m_rd); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        regs[0] = '0;
        rst = 1'b1;
        idle();
        test_reset();
        test_decode();
        test_hazard();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
